// File: rtl/nightlight_ctrl.sv
// Nightlight sequencing controller: holds the BCD on-duration, loads the countdown
// timer, generates one-second ticks and runs the blink-warning phase before lamp-off.
module nightlight_ctrl #(
  parameter int unsigned TICK_DIV   = 50_000_000,
  parameter int unsigned WARN_TICKS = 10,
  parameter logic [23:0] DEF_DUR    = 24'h001500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dark,
  input  logic        motion,
  input  logic        btn,
  input  logic        cfg_we,
  input  logic [23:0] cfg_dur,
  output logic        cfg_err,
  input  logic        tmr_zero,
  output logic        tmr_set,
  output logic [23:0] tmr_load_val,
  output logic        tmr_tick,
  output logic        light,
  output logic [1:0]  state
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int WW = $clog2(WARN_TICKS + 1);
  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
  localparam logic [WW-1:0] W_LAST = WW'(WARN_TICKS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, WARN = 2'd3} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d, presc_nx;
  logic [WW-1:0] warn_q, warn_d;
  logic          light_q, light_d;
  logic          man_q, man_d;
  logic          set_q, set_d;
  logic          tick_q, tick_d;
  logic          err_q, err_d;
  logic [23:0]   dur_q, dur_d;
  logic          dark_q, motion_q, btn_q;

  logic [3:0] ht, ho, mt, mo, st, so;
  logic       dur_ok, presc_term;
  logic       rise_btn, rise_dark, rise_mot, fall_dark;

  assign {ht, ho, mt, mo, st, so} = cfg_dur;
  // Digit ranges alone would admit 24..29 hours, hence the extra hour check.
  assign dur_ok = (ht <= 4'd2) && (ho <= 4'd9) && (mt <= 4'd5) && (mo <= 4'd9) &&
                  (st <= 4'd5) && (so <= 4'd9) && !((ht == 4'd2) && (ho > 4'd3));

  assign rise_btn  = btn & ~btn_q;
  assign rise_dark = dark & ~dark_q;
  assign fall_dark = ~dark & dark_q;
  assign rise_mot  = motion & ~motion_q;

  assign presc_term = (presc_q == P_LAST);
  assign presc_nx   = presc_term ? '0 : presc_q + 1'b1;

  always_comb begin
    dur_d = (cfg_we && dur_ok) ? cfg_dur : dur_q;
    err_d = cfg_we && !dur_ok;
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    warn_d  = warn_q;
    light_d = light_q;
    man_d   = man_q;
    set_d   = 1'b0;
    case (state_q)
      IDLE: begin
        light_d = 1'b0;
        presc_d = '0;
        man_d   = 1'b0;
        if (rise_btn || rise_dark || (rise_mot && dark)) begin
          state_d = LOAD;
          set_d   = 1'b1;
          light_d = 1'b1;
          man_d   = rise_btn;
        end
      end
      LOAD: begin
        state_d = RUN;
        light_d = 1'b1;
        presc_d = '0;
      end
      default: begin
        presc_d = presc_nx;
        if (rise_btn || (!rise_mot && fall_dark && !man_q)) begin
          state_d = IDLE;
          light_d = 1'b0;
          man_d   = 1'b0;
          presc_d = '0;
        end else if (rise_mot) begin
          state_d = LOAD;
          set_d   = 1'b1;
          light_d = 1'b1;
          presc_d = '0;
        end else if (state_q == RUN) begin
          if (tmr_zero) begin
            state_d = WARN;
            light_d = 1'b0;
            warn_d  = '0;
          end
        end else if (presc_term) begin
          if (warn_q == W_LAST) begin
            state_d = IDLE;
            light_d = 1'b0;
            man_d   = 1'b0;
            presc_d = '0;
          end else begin
            light_d = ~light_q;
            warn_d  = warn_q + 1'b1;
          end
        end
      end
    endcase
    // Tick is registered one edge early so it lines up with the terminal count.
    tick_d = (state_d == RUN) && (presc_d == P_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      presc_q  <= '0;
      warn_q   <= '0;
      light_q  <= 1'b0;
      man_q    <= 1'b0;
      set_q    <= 1'b0;
      tick_q   <= 1'b0;
      err_q    <= 1'b0;
      dur_q    <= DEF_DUR;
      dark_q   <= 1'b0;
      motion_q <= 1'b0;
      btn_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      warn_q   <= warn_d;
      light_q  <= light_d;
      man_q    <= man_d;
      set_q    <= set_d;
      tick_q   <= tick_d;
      err_q    <= err_d;
      dur_q    <= dur_d;
      dark_q   <= dark;
      motion_q <= motion;
      btn_q    <= btn;
    end
  end

  assign state        = state_q;
  assign light        = light_q;
  assign tmr_set      = set_q;
  assign tmr_tick     = tick_q;
  assign cfg_err      = err_q;
  assign tmr_load_val = dur_q;

endmodule

// File: tb/tb_nightlight_ctrl.sv
// Directed bench for nightlight_ctrl with a behavioural BCD countdown timer and an
// expectation queue that is filled at stimulus time and drained at sample time.
module tb_nightlight_ctrl;
  localparam int TD = 4;
  localparam int WT = 4;
  localparam logic [23:0] DEF = 24'h001500;

  logic        clk = 1'b0;
  logic        rst, dark, motion, btn, cfg_we;
  logic [23:0] cfg_dur;
  logic        cfg_err, tmr_zero, tmr_set, tmr_tick, light;
  logic [23:0] tmr_load_val;
  logic [1:0]  state;
  logic [23:0] tmr_val = 24'h0;

  int checks = 0;
  int errors = 0;

  typedef struct { string tag; logic [31:0] val; } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  nightlight_ctrl #(.TICK_DIV(TD), .WARN_TICKS(WT), .DEF_DUR(DEF)) dut (
    .clk(clk), .rst(rst), .dark(dark), .motion(motion), .btn(btn),
    .cfg_we(cfg_we), .cfg_dur(cfg_dur), .cfg_err(cfg_err), .tmr_zero(tmr_zero),
    .tmr_set(tmr_set), .tmr_load_val(tmr_load_val), .tmr_tick(tmr_tick),
    .light(light), .state(state)
  );

  // Timer model works in seconds so it shares no digit logic with anything it checks.
  function automatic logic [23:0] bcd_dec(input logic [23:0] v);
    int s, h, m, x;
    s = (int'(v[23:20]) * 10 + int'(v[19:16])) * 3600 +
        (int'(v[15:12]) * 10 + int'(v[11:8])) * 60 + int'(v[7:4]) * 10 + int'(v[3:0]) - 1;
    h = s / 3600; m = (s / 60) % 60; x = s % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
  endfunction

  always @(posedge clk) begin
    if (tmr_set) tmr_val <= tmr_load_val;
    else if (tmr_tick && tmr_val != 24'h0) tmr_val <= bcd_dec(tmr_val);
  end
  assign tmr_zero = (tmr_val == 24'h0);

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] o);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %0h expected <none>", o);
    end else begin
      e = sb.pop_front();
      assert (o === e.val) else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, o, e.val);
      end
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [23:0] v);
    cfg_we = 1'b1; cfg_dur = v;
    cyc(1);
    cfg_we = 1'b0;
  endtask

  initial begin
    int tk[$];
    int wentry, wticks, t0, t1, t2;
    logic        lv[0:15];
    logic [1:0]  sv[0:15];
    logic [23:0] tv;

    rst = 1'b1; dark = 1'b0; motion = 1'b0; btn = 1'b0; cfg_we = 1'b0; cfg_dur = '0;
    cyc(3);
    push("rst_state", 0); push("rst_light", 0); push("rst_set", 0);
    push("rst_tick", 0); push("rst_err", 0); push("rst_dur", DEF);
    pop_chk(state); pop_chk(light); pop_chk(tmr_set);
    pop_chk(tmr_tick); pop_chk(cfg_err); pop_chk(tmr_load_val);
    rst = 1'b0;
    cyc(1);
    push("idle_hold", 0); pop_chk(state);

    // Duration register: legal, illegal digit, illegal hour, and the max legal value.
    push("wr3_err", 0); push("wr3_val", 24'h000003);
    wr(24'h000003); pop_chk(cfg_err); pop_chk(tmr_load_val);
    push("wr_mt6_err", 1); push("wr_mt6_val", 24'h000003);
    wr(24'h006000); pop_chk(cfg_err); pop_chk(tmr_load_val);
    push("err_one_cycle", 0); cyc(1); pop_chk(cfg_err);
    push("wr_24h_err", 1); push("wr_24h_val", 24'h000003);
    wr(24'h240000); pop_chk(cfg_err); pop_chk(tmr_load_val);
    push("wr_st6_err", 1); wr(24'h000060); pop_chk(cfg_err);
    push("wr_max_err", 0); push("wr_max_val", 24'h235959);
    wr(24'h235959); pop_chk(cfg_err); pop_chk(tmr_load_val);
    push("wr3b_val", 24'h000003); wr(24'h000003); pop_chk(tmr_load_val);

    // Dark rise: full countdown of three ticks, then the warning blink.
    push("dk_state", 1); push("dk_set", 1); push("dk_light", 1); push("dk_val", 24'h000003);
    dark = 1'b1; cyc(1);
    pop_chk(state); pop_chk(tmr_set); pop_chk(light); pop_chk(tmr_load_val);
    push("tick_count", 3); push("tick0", 4); push("tick1", 8); push("tick2", 12);
    push("warn_entry", 14); push("warn_light0", 0);
    wentry = -1;
    for (int c = 1; c <= 40; c++) begin
      cyc(1);
      if (state == 2'd3) begin wentry = c; break; end
      if (tmr_tick) tk.push_back(c);
    end
    t0 = (tk.size() > 0) ? tk[0] : -1;
    t1 = (tk.size() > 1) ? tk[1] : -1;
    t2 = (tk.size() > 2) ? tk[2] : -1;
    pop_chk(tk.size()); pop_chk(t0); pop_chk(t1); pop_chk(t2);
    pop_chk(wentry); pop_chk(light);
    wticks = 0;
    for (int k = 1; k <= 15; k++) begin
      cyc(1);
      lv[k] = light; sv[k] = state;
      if (state == 2'd3 && tmr_tick) wticks++;
    end
    push("warn_l2", 0); push("warn_l3", 1); push("warn_l7", 0); push("warn_l11", 1);
    push("warn_last_state", 3); push("warn_exit_state", 0); push("warn_exit_light", 0);
    push("warn_no_tick", 0);
    pop_chk(lv[2]); pop_chk(lv[3]); pop_chk(lv[7]); pop_chk(lv[11]);
    pop_chk(sv[14]); pop_chk(sv[15]); pop_chk(lv[15]); pop_chk(wticks);

    // Motion retrigger at 00:00:01 in RUN, then again during WARN.
    push("mot_load", 1);
    motion = 1'b1; cyc(1); pop_chk(state);
    motion = 1'b0;
    for (int c = 0; c < 30; c++) begin
      cyc(1);
      if (state == 2'd2 && tmr_val == 24'h000001) break;
    end
    push("rt_remain1", 24'h000001); pop_chk(tmr_val);
    push("rt_state", 1); push("rt_set", 1);
    motion = 1'b1; cyc(1); pop_chk(state); pop_chk(tmr_set);
    motion = 1'b0;
    push("rt_run", 2); push("rt_reload", 24'h000003);
    cyc(1); pop_chk(state); pop_chk(tmr_val);
    for (int c = 0; c < 40; c++) begin
      if (state == 2'd3) break;
      cyc(1);
    end
    push("rt_reach_warn", 3); pop_chk(state);
    push("wrt_state", 1);
    motion = 1'b1; cyc(1); pop_chk(state);
    motion = 1'b0;
    push("wrt_run", 2); push("wrt_reload", 24'h000003);
    cyc(1); pop_chk(state); pop_chk(tmr_val);
    push("btn_off", 0); push("btn_off_light", 0);
    btn = 1'b1; cyc(1); pop_chk(state); pop_chk(light);
    btn = 1'b0;

    // Manual mode: dark fall ignored, second button rise turns off.
    push("dfall_idle", 0);
    dark = 1'b0; cyc(1); pop_chk(state);
    push("man_load", 1);
    btn = 1'b1; cyc(1); pop_chk(state);
    btn = 1'b0;
    push("man_run", 2); cyc(1); pop_chk(state);
    dark = 1'b1; cyc(1);
    dark = 1'b0; cyc(1);
    push("man_dfall_run", 2); push("man_dfall_light", 1);
    pop_chk(state); pop_chk(light);
    push("man_off", 0); push("man_off_light", 0);
    btn = 1'b1; cyc(1); pop_chk(state); pop_chk(light);
    btn = 1'b0;

    // Priority: btn beats motion; dark fall beats tmr_zero.
    dark = 1'b1; cyc(2);
    push("pr_run", 2); pop_chk(state);
    push("pr_btn_mot", 0);
    btn = 1'b1; motion = 1'b1; cyc(1); pop_chk(state);
    btn = 1'b0; motion = 1'b0; cyc(1);
    push("pr_mot_load", 1);
    motion = 1'b1; cyc(1); pop_chk(state);
    motion = 1'b0;
    for (int c = 0; c < 30; c++) begin
      cyc(1);
      if (state == 2'd2 && tmr_zero) break;
    end
    push("pr_zero_seen", 1); pop_chk(tmr_zero);
    push("pr_dfall_idle", 0);
    dark = 1'b0; cyc(1); pop_chk(state);

    // Write during LOAD: timer gets the old value, register takes the new one.
    push("ld_state", 1); push("ld_val", 24'h000003);
    dark = 1'b1; cyc(1); pop_chk(state); pop_chk(tmr_load_val);
    cfg_we = 1'b1; cfg_dur = 24'h000000; cyc(1); cfg_we = 1'b0;
    push("ld_run", 2); push("ld_timer_old", 24'h000003);
    push("ld_reg_new", 24'h000000); push("ld_err", 0);
    pop_chk(state); pop_chk(tmr_val); pop_chk(tmr_load_val); pop_chk(cfg_err);
    push("ld_off", 0);
    btn = 1'b1; cyc(1); pop_chk(state);
    btn = 1'b0; cyc(1);

    // Zero duration: LOAD, one RUN cycle, then WARN without ticks.
    push("z_load", 1); push("z_set", 1);
    btn = 1'b1; cyc(1); pop_chk(state); pop_chk(tmr_set);
    btn = 1'b0;
    push("z_run", 2); push("z_zero", 1); push("z_tick_run", 0);
    cyc(1); pop_chk(state); pop_chk(tmr_zero); pop_chk(tmr_tick);
    push("z_warn", 3); push("z_warn_light", 0);
    cyc(1); pop_chk(state); pop_chk(light);
    wticks = 0;
    for (int k = 0; k < 6; k++) begin
      cyc(1);
      if (tmr_tick) wticks++;
    end
    push("z_no_tick", 0); pop_chk(wticks);
    push("z_off", 0);
    btn = 1'b1; cyc(1); pop_chk(state);
    btn = 1'b0; cyc(1);

    // Reset mid-RUN, then power-up-in-darkness rise.
    wr(24'h000003);
    btn = 1'b1; cyc(1); btn = 1'b0;
    cyc(2);
    push("rr_run", 2); pop_chk(state);
    tv = tmr_val;
    rst = 1'b1; cyc(1);
    push("rr_state", 0); push("rr_light", 0); push("rr_set", 0);
    push("rr_tick", 0); push("rr_err", 0); push("rr_dur", DEF); push("rr_no_reload", tv);
    pop_chk(state); pop_chk(light); pop_chk(tmr_set);
    pop_chk(tmr_tick); pop_chk(cfg_err); pop_chk(tmr_load_val); pop_chk(tmr_val);
    rst = 1'b0;
    push("pwr_dark_load", 1); push("pwr_dark_val", DEF);
    cyc(1); pop_chk(state); pop_chk(tmr_load_val);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/nightlight_ctrl.md
# nightlight_ctrl

Sequencing controller for the nightlight's BCD HH:MM:SS countdown timer. It holds the programmed on-duration and loads it into the timer. It generates the one-second decrement ticks from the system clock and turns the lamp on from ambient-dark, motion and button events. When the timer reaches zero it runs a blinking warning phase, then switches the lamp off.

## Interface
- `TICK_DIV`, default 50_000_000: clk cycles per tick; legal range ≥2.
- `WARN_TICKS`, default 10: number of ticks spent in the blink-warning phase; legal range ≥1.
- `DEF_DUR`, default 24'h001500: reset value of the duration register, in BCD HHMMSS (00:15:00).

Ports:
- `clk` in 1: system clock. Everything is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `dark` in 1: ambient-dark level, synchronous to clk.
- `motion` in 1: motion sensor level, synchronous.
- `btn` in 1: manual toggle button level, synchronous and already debounced.
- `cfg_we` in 1: one-cycle write strobe for the duration register.
- `cfg_dur` in 24: BCD {ht,ho,mt,mo,st,so}; sampled when `cfg_we`=1.
- `cfg_err` out 1: one-cycle pulse, the cycle after a rejected write.
- `tmr_zero` in 1: from the timer; 1 when all six digits are 0.
- `tmr_set` out 1: one-cycle load pulse to the timer.
- `tmr_load_val` out 24: BCD value to load; always equal to the duration register.
- `tmr_tick` out 1: one-cycle decrement enable to the timer.
- `light` out 1: lamp drive.
- `state` out 2: current state. 0=IDLE, 1=LOAD, 2=RUN, 3=WARN.

## Operation
- Edge detection: registered copies `dark_q`, `motion_q`, `btn_q`, each reset to 0.
  - A rise is input=1 with the registered copy=0.
  - A fall is input=0 with the registered copy=1.
  - Because the copies reset to 0, power-up in darkness produces a `dark` rise.
- Duration register:
  - Resets to `DEF_DUR`.
  - A write is accepted only if every digit is legal: ht≤2, ho≤9, mt≤5, mo≤9, st≤5, so≤9, and the value is ≤23:59:59.
  - An illegal write leaves the register unchanged and pulses `cfg_err`.
  - Writes are accepted in any state. They never alter a countdown already in progress.
- Manual flag `man`: set when LOAD is entered via a `btn` rise; cleared on entry to IDLE.
- IDLE: `light`=0; the prescaler is held at 0. Go to LOAD on any of:
  - `btn` rise;
  - `dark` rise;
  - `motion` rise while `dark`=1.
- LOAD: exactly one cycle.
  - `tmr_set`=1, `light`=1, prescaler cleared to 0.
  - Next state is always RUN.
- RUN: `light`=1. The prescaler counts 0..`TICK_DIV`-1 and wraps. `tmr_tick`=1 on each cycle where the count equals `TICK_DIV`-1.
- WARN:
  - On entry: `light`=0 and the warn counter is set to 0.
  - Each terminal count toggles `light` and increments the warn counter. `tmr_tick` stays 0.
  - When the warn counter reaches `WARN_TICKS`, go to IDLE.
- Exit priority in RUN/WARN, highest first:
  1. `btn` rise → IDLE.
  2. `motion` rise → LOAD (retrigger; `man` unchanged).
  3. `dark` fall with `man`=0 → IDLE.
  4. RUN only: `tmr_zero`=1 → WARN.
  5. WARN only: warn expiry → IDLE.
- No tick is issued on the cycle a RUN/WARN exit is taken.
- A duration of 00:00:00 is legal: RUN sees `tmr_zero` on its first cycle, so the sequence is LOAD→RUN→WARN.

## Timing
- Reset values:
  - `state`=IDLE.
  - `light`, `tmr_set`, `tmr_tick`, `cfg_err` = 0.
  - `tmr_load_val`=`DEF_DUR`; prescaler, warn counter and `man` = 0.
- All outputs are registered, or decoded only from registered state.
- Trigger edge at cycle N: `state`=LOAD with `tmr_set`=1 at N+1, then RUN at N+2. The timer loads at the N+1→N+2 edge.
- First `tmr_tick` comes `TICK_DIV` cycles after LOAD.
- `tmr_zero` is sampled in RUN; WARN is entered on the following cycle.
- `cfg_we` in the LOAD cycle: the timer receives the old value. The new value applies from the next LOAD.
- `rst` mid-operation: IDLE on the next cycle with `light`=0. The timer is not reloaded.

## Test plan
With `TICK_DIV`=4, `WARN_TICKS`=4 and a behavioural BCD timer model:
- Reset, then `dark`=1 with duration written as 00:00:03 → LOAD with `tmr_set` and `tmr_load_val`=24'h000003. Exactly 3 `tmr_tick` pulses 4 cycles apart, then WARN. `light` shows 0,1,0,1 over 4 ticks, then IDLE with `light`=0.
- `cfg_dur`=24'h006000 (mt=6) → `cfg_err` pulses; `tmr_load_val` unchanged. `cfg_dur`=24'h240000 → also rejected.
- In RUN, `motion` rise at remaining 00:00:01 → LOAD, timer reloaded to the full duration. A `motion` rise during WARN also reloads.
- `dark`=0 with a `btn` rise → RUN with `man`=1. A `dark` fall has no effect. A second `btn` rise → IDLE, `light`=0.
- Same cycle `btn` rise + `motion` rise in RUN → IDLE. `dark` fall + `tmr_zero` in RUN with `man`=0 → IDLE, not WARN.
- Duration 00:00:00 → LOAD, RUN (1 cycle), WARN with no `tmr_tick`. `rst` during RUN → IDLE, outputs at reset values.
